multi_channel_latency_meter: RTL and testbench
==============================================

// Module: multi_channel_latency_meter
// PURPOSE
//  Measures ping->echo round-trip latency on NCHAN independent links in one clock domain.
//  Per channel it keeps the latest latency, a filtered average, good/timeout/abort counts and
//  optional min/max. A channel-select readout feeds the system CSR bank. It replaces the
//  single-link latency monitor where several fibre links are timed at once.
// PARAMETERS
//  NCHAN          4     number of ping/echo channels (1..16)
//  TICK_LIMIT     1000  timeout in sysClk cycles; must satisfy LATENCY_WIDTH<=16
//  FILTER_SHIFT   3     averaging filter shift (IIR weight 1/2^FILTER_SHIFT)
//  Derived: LATENCY_WIDTH=$clog2(TICK_LIMIT+1), SEL_WIDTH=$clog2(NCHAN) (min 1)
// PORTS
//  sysClk      in   1          clock
//  sysReset_n  in   1          asynchronous, active-low reset
//  rxValid     in   NCHAN      per-channel link valid (already synchronous)
//  ping        in   NCHAN      per-channel ping toggle (each edge = one event, synchronous)
//  echo        in   NCHAN      per-channel echo toggle (synchronous)
//  clearStats  in   1          one-cycle pulse: clear statistics of all channels
//  chanSel     in   SEL_WIDTH  readout channel select
//  newValue    out  NCHAN      one-cycle strobe per completed measurement
//  csrLatency  out  32         {average[15:0], latest[15:0]}, fields zero-extended
//  csrMinMax   out  32         {max[15:0], min[15:0]}
//  csrCounts   out  32         {goodCount[15:0], timeoutCount[7:0], abortCount[7:0]}
// BEHAVIOUR
//  - Reset: all outputs, counters, latest, filter and max = 0. min = all ones. FSMs go to IDLE.
//  - Events: pingEvt/echoEvt = input XOR registered previous value (1-cycle detect).
//    The previous-value registers reset to 0.
//  - FSM per channel, IDLE/MEASURE:
//    IDLE: pingEvt && rxValid -> MEASURE with counter=1. echoEvt is ignored.
//    MEASURE: counter+1 each cycle. Priority per cycle:
//      1 !rxValid -> IDLE, abort+1
//      2 echoEvt -> complete with latency=counter. If pingEvt is in the same cycle, stay in
//        MEASURE with counter=1; otherwise go to IDLE.
//      3 pingEvt (no echo) -> restart with counter=1, abort+1
//      4 counter==TICK_LIMIT -> IDLE, timeout+1, latest unchanged
//  - Latency = cycle distance between the ping and echo toggle edges. An echo edge k cycles
//    after the ping edge gives latency k.
//  - Completion (registered, newValue strobe in the same cycle as the update):
//    latest<=latency, good+1.
//    filter (LATENCY_WIDTH+FILTER_SHIFT bits) <= filter - (filter>>FILTER_SHIFT) + latency.
//    The first sample after reset or clear preloads filter = latency<<FILTER_SHIFT.
//    average = filter>>FILTER_SHIFT (truncating).
//  - Counters saturate: good at 16'hFFFF, timeout and abort at 8'hFF.
//  - clearStats zeroes good/timeout/abort, sets min=all ones and max=0, and re-arms the filter
//    preload. It does not touch the FSMs or latest.
//    If a completion lands in the same cycle, the clear applies first; that sample becomes the
//    first post-clear sample (good=1, min=max=sample).
//  - Readout is registered, valid 1 cycle after chanSel changes.
//    chanSel>=NCHAN reads all three CSRs as 0.
//    The min field reads 0 while goodCount==0.
//  - An asserted reset mid-measurement aborts immediately with no count or strobe.
//    After release, pings need a fresh toggle edge.
// CONFIGURATION
//  LATENCY_METER_MINMAX_EN defined:
//    per-channel min/max registers update on each completion
//    (min<=min(min,lat), max<=max(max,lat)).
//  Undefined: no min/max registers are built and csrMinMax is tied to 0.
// TESTING (NCHAN=4, TICK_LIMIT=1000, FILTER_SHIFT=3)
//  - Ch0 ping edge, echo edge 37 cycles later -> newValue=4'b0001 for one cycle.
//    chanSel=0: latest=37, average=37, good=1.
//  - Ch1 ping, no echo -> IDLE after 1000 cycles. timeout=1, good=0, latest=0, no strobe.
//  - Ch2 rxValid low mid-measurement, then a second ping mid-measurement -> abort=2.
//    Ch3 simultaneous echo+ping -> latest recorded and a new measurement starts.
//  - Ch0 samples 40 then 48 after clearStats -> filter 320 then 328, average=41, good=2.
//  - With macro: samples 37,100,20 -> min=20, max=100; clearStats -> csrMinMax=0, counts 0.
//    Without macro: csrMinMax=0.
//  - chanSel=5 -> all CSRs 0. sysReset_n low mid-measurement -> outputs 0, no strobe.

Source files
------------

// File: rtl/multi_channel_latency_meter.sv
// multi_channel_latency_meter: ping->echo round-trip timer on NCHAN links.
// Per channel: latest, IIR average, good/timeout/abort counts, optional min/max.
// Optional feature macro: LATENCY_METER_MINMAX_EN (per-channel min/max).
// Ports:
//   sysClk, sysReset_n    clock, async active-low reset
//   rxValid, ping, echo   per-channel link valid and toggle inputs
//   clearStats            pulse: clear statistics of all channels
//   chanSel               readout channel select
//   newValue              per-channel completion strobe
//   csrLatency            {average, latest}
//   csrMinMax             {max, min}  (0 without the macro)
//   csrCounts             {good[15:0], timeout[7:0], abort[7:0]}
module multi_channel_latency_meter #(
  parameter int NCHAN        = 4,
  parameter int TICK_LIMIT   = 1000,
  parameter int FILTER_SHIFT = 3,
  localparam int LATENCY_WIDTH = $clog2(TICK_LIMIT + 1),
  localparam int SEL_WIDTH     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                 sysClk,
  input  logic                 sysReset_n,
  input  logic [NCHAN-1:0]     rxValid,
  input  logic [NCHAN-1:0]     ping,
  input  logic [NCHAN-1:0]     echo,
  input  logic                 clearStats,
  input  logic [SEL_WIDTH-1:0] chanSel,
  output logic [NCHAN-1:0]     newValue,
  output logic [31:0]          csrLatency,
  output logic [31:0]          csrMinMax,
  output logic [31:0]          csrCounts
);

  localparam int LW = LATENCY_WIDTH;
  localparam int FW = LATENCY_WIDTH + FILTER_SHIFT;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  logic [NCHAN-1:0] pingPrev;
  logic [NCHAN-1:0] echoPrev;
  logic [NCHAN-1:0] pingEvt;
  logic [NCHAN-1:0] echoEvt;
  logic [NCHAN-1:0] doneVec;

  logic [LW-1:0] latestArr [NCHAN];
  logic [LW-1:0] avgArr    [NCHAN];
  logic [15:0]   goodArr   [NCHAN];
  logic [7:0]    toArr     [NCHAN];
  logic [7:0]    abArr     [NCHAN];
`ifdef LATENCY_METER_MINMAX_EN
  logic [LW-1:0] minArr    [NCHAN];
  logic [LW-1:0] maxArr    [NCHAN];
`endif

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      pingPrev <= '0;
      echoPrev <= '0;
    end else begin
      pingPrev <= ping;
      echoPrev <= echo;
    end
  end

  assign pingEvt = ping ^ pingPrev;
  assign echoEvt = echo ^ echoPrev;

  for (genvar g = 0; g < NCHAN; g++) begin : gChan
    state_t        stateQ;
    state_t        stateD;
    logic [LW-1:0] cntQ;
    logic [LW-1:0] cntD;
    logic          done;
    logic          abortInc;
    logic          toInc;

    logic [LW-1:0] latestQ;
    logic [FW-1:0] filtQ;
    logic [FW-1:0] filtD;
    logic [FW-1:0] sampleExt;
    logic          firstQ;
    logic [15:0]   goodQ;
    logic [7:0]    toQ;
    logic [7:0]    abQ;

    always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
        stateQ <= IDLE;
        cntQ   <= '0;
      end else begin
        stateQ <= stateD;
        cntQ   <= cntD;
      end
    end

    always_comb begin
      stateD   = stateQ;
      cntD     = cntQ;
      done     = 1'b0;
      abortInc = 1'b0;
      toInc    = 1'b0;
      unique case (stateQ)
        IDLE: begin
          if (pingEvt[g] && rxValid[g]) begin
            stateD = MEASURE;
            cntD   = LW'(1);
          end
        end
        MEASURE: begin
          cntD = cntQ + 1'b1;
          if (!rxValid[g]) begin
            stateD   = IDLE;
            abortInc = 1'b1;
          end else if (echoEvt[g]) begin
            done = 1'b1;
            if (pingEvt[g]) begin
              cntD = LW'(1);
            end else begin
              stateD = IDLE;
            end
          end else if (pingEvt[g]) begin
            cntD     = LW'(1);
            abortInc = 1'b1;
          end else if (cntQ == LW'(TICK_LIMIT)) begin
            stateD = IDLE;
            toInc  = 1'b1;
          end
        end
        default: stateD = IDLE;
      endcase
    end

    assign sampleExt = FW'(cntQ);
    assign filtD = filtQ - (filtQ >> FILTER_SHIFT) + sampleExt;

    // A clear in the completion cycle takes effect first, so the
    // sample becomes the first post-clear sample.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
        latestQ <= '0;
        filtQ   <= '0;
        firstQ  <= 1'b1;
        goodQ   <= '0;
        toQ     <= '0;
        abQ     <= '0;
      end else begin
        if (done) begin
          latestQ <= cntQ;
          firstQ  <= 1'b0;
          if (clearStats || firstQ) begin
            filtQ <= sampleExt << FILTER_SHIFT;
          end else begin
            filtQ <= filtD;
          end
        end else if (clearStats) begin
          firstQ <= 1'b1;
        end
        if (clearStats) begin
          goodQ <= {15'd0, done};
          toQ   <= {7'd0, toInc};
          abQ   <= {7'd0, abortInc};
        end else begin
          if (done && goodQ != 16'hFFFF) goodQ <= goodQ + 1'b1;
          if (toInc && toQ != 8'hFF) toQ <= toQ + 1'b1;
          if (abortInc && abQ != 8'hFF) abQ <= abQ + 1'b1;
        end
      end
    end

`ifdef LATENCY_METER_MINMAX_EN
    logic [LW-1:0] minQ;
    logic [LW-1:0] maxQ;

    always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
        minQ <= '1;
        maxQ <= '0;
      end else if (done) begin
        if (clearStats || cntQ < minQ) minQ <= cntQ;
        if (clearStats || cntQ > maxQ) maxQ <= cntQ;
      end else if (clearStats) begin
        minQ <= '1;
        maxQ <= '0;
      end
    end

    assign minArr[g] = minQ;
    assign maxArr[g] = maxQ;
`endif

    assign doneVec[g]   = done;
    assign latestArr[g] = latestQ;
    assign avgArr[g]    = LW'(filtQ >> FILTER_SHIFT);
    assign goodArr[g]   = goodQ;
    assign toArr[g]     = toQ;
    assign abArr[g]     = abQ;
  end

  logic [31:0] rdLat;
  logic [31:0] rdCnt;
  logic [31:0] rdMm;

  // Unmatched selects (chanSel >= NCHAN) fall through to zero.
  always_comb begin
    rdLat = '0;
    rdCnt = '0;
    rdMm  = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (chanSel == SEL_WIDTH'(i)) begin
        rdLat = {16'(avgArr[i]), 16'(latestArr[i])};
        rdCnt = {goodArr[i], toArr[i], abArr[i]};
`ifdef LATENCY_METER_MINMAX_EN
        rdMm[31:16] = 16'(maxArr[i]);
        rdMm[15:0]  = (goodArr[i] == 16'd0) ? 16'd0
                                            : 16'(minArr[i]);
`endif
      end
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      newValue   <= '0;
      csrLatency <= '0;
      csrCounts  <= '0;
    end else begin
      newValue   <= doneVec;
      csrLatency <= rdLat;
      csrCounts  <= rdCnt;
    end
  end

`ifdef LATENCY_METER_MINMAX_EN
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      csrMinMax <= '0;
    end else begin
      csrMinMax <= rdMm;
    end
  end
`else
  logic unusedMm;
  assign unusedMm  = ^rdMm;
  assign csrMinMax = '0;
`endif

endmodule

// File: tb/tb_multi_channel_latency_meter.sv
// Bench for multi_channel_latency_meter: directed cases plus random
// traffic against a timestamp-based reference model.
module tb_multi_channel_latency_meter;
  localparam int NCHAN = 4;
  localparam int TICK  = 1000;
  localparam int MINONES = 1023;

  logic             sysClk     = 1'b0;
  logic             sysReset_n = 1'b0;
  logic [NCHAN-1:0] rxValid    = '0;
  logic [NCHAN-1:0] ping       = '0;
  logic [NCHAN-1:0] echo       = '0;
  logic             clearStats = 1'b0;
  logic [1:0]       chanSel    = '0;
  logic [NCHAN-1:0] newValue;
  logic [31:0]      csrLatency;
  logic [31:0]      csrMinMax;
  logic [31:0]      csrCounts;

  logic [2:0]       chanSel5   = 3'd5;
  logic [4:0]       newValue5;
  logic [31:0]      csrLatency5;
  logic [31:0]      csrMinMax5;
  logic [31:0]      csrCounts5;

  always #5 sysClk = ~sysClk;

  multi_channel_latency_meter dut (
    .sysClk     (sysClk),
    .sysReset_n (sysReset_n),
    .rxValid    (rxValid),
    .ping       (ping),
    .echo       (echo),
    .clearStats (clearStats),
    .chanSel    (chanSel),
    .newValue   (newValue),
    .csrLatency (csrLatency),
    .csrMinMax  (csrMinMax),
    .csrCounts  (csrCounts)
  );

  multi_channel_latency_meter #(.NCHAN(5)) dut5 (
    .sysClk     (sysClk),
    .sysReset_n (sysReset_n),
    .rxValid    ({1'b1, rxValid}),
    .ping       ({1'b0, ping}),
    .echo       ({1'b0, echo}),
    .clearStats (clearStats),
    .chanSel    (chanSel5),
    .newValue   (newValue5),
    .csrLatency (csrLatency5),
    .csrMinMax  (csrMinMax5),
    .csrCounts  (csrCounts5)
  );

  int totalCnt = 0;
  int failCnt  = 0;

  int edgeN = 0;
  bit mMeas  [NCHAN];
  int mStart [NCHAN];
  bit mPp    [NCHAN];
  bit mEp    [NCHAN];
  int mLatest[NCHAN];
  int mFilt  [NCHAN];
  bit mFirst [NCHAN];
  int mGood  [NCHAN];
  int mTo    [NCHAN];
  int mAb    [NCHAN];
  int mMin   [NCHAN];
  int mMax   [NCHAN];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void mReset();
    for (int c = 0; c < NCHAN; c++) begin
      mMeas[c] = 0; mStart[c] = 0; mPp[c] = 0; mEp[c] = 0;
      mLatest[c] = 0; mFilt[c] = 0; mFirst[c] = 1;
      mGood[c] = 0; mTo[c] = 0; mAb[c] = 0;
      mMin[c] = MINONES; mMax[c] = 0;
    end
  endfunction

  function automatic void complete(input int c, input int lat);
    mLatest[c] = lat;
    if (mGood[c] < 65535) mGood[c]++;
    if (mFirst[c]) mFilt[c] = lat * 8;
    else mFilt[c] = mFilt[c] - mFilt[c] / 8 + lat;
    mFirst[c] = 0;
    if (lat < mMin[c]) mMin[c] = lat;
    if (lat > mMax[c]) mMax[c] = lat;
  endfunction

  function automatic void csrExp(input int sel, output logic [31:0] l,
                                 output logic [31:0] m,
                                 output logic [31:0] k);
    l = '0; m = '0; k = '0;
    if (sel < NCHAN) begin
      l = {16'(mFilt[sel] / 8), 16'(mLatest[sel])};
`ifdef LATENCY_METER_MINMAX_EN
      m = {16'(mMax[sel]), (mGood[sel] == 0) ? 16'd0 : 16'(mMin[sel])};
`endif
      k = {16'(mGood[sel]), 8'(mTo[sel]), 8'(mAb[sel])};
    end
  endfunction

  task automatic step();
    logic [31:0] eL, eM, eC, fL, fM, fC;
    logic [NCHAN-1:0] eN;
    bit pe, ee;
    int age;
    csrExp(int'(chanSel), eL, eM, eC);
    csrExp(int'(chanSel5), fL, fM, fC);
    eN = '0;
    if (clearStats) begin
      for (int c = 0; c < NCHAN; c++) begin
        mGood[c] = 0; mTo[c] = 0; mAb[c] = 0;
        mMin[c] = MINONES; mMax[c] = 0; mFirst[c] = 1;
      end
    end
    for (int c = 0; c < NCHAN; c++) begin
      pe = ping[c] ^ mPp[c];
      ee = echo[c] ^ mEp[c];
      mPp[c] = ping[c];
      mEp[c] = echo[c];
      if (!mMeas[c]) begin
        if (pe && rxValid[c]) begin
          mMeas[c] = 1; mStart[c] = edgeN;
        end
      end else begin
        age = edgeN - mStart[c];
        if (!rxValid[c]) begin
          mMeas[c] = 0;
          if (mAb[c] < 255) mAb[c]++;
        end else if (ee) begin
          eN[c] = 1'b1;
          complete(c, age);
          if (pe) mStart[c] = edgeN;
          else mMeas[c] = 0;
        end else if (pe) begin
          mStart[c] = edgeN;
          if (mAb[c] < 255) mAb[c]++;
        end else if (age == TICK) begin
          mMeas[c] = 0;
          if (mTo[c] < 255) mTo[c]++;
        end
      end
    end
    edgeN++;
    @(posedge sysClk);
    #1;
    chk("newValue", 32'(newValue), 32'(eN));
    chk("csrLatency", csrLatency, eL);
    chk("csrMinMax", csrMinMax, eM);
    chk("csrCounts", csrCounts, eC);
    chk("newValue5", 32'(newValue5), 32'(eN));
    chk("csrLatency5", csrLatency5, fL);
    chk("csrMinMax5", csrMinMax5, fM);
    chk("csrCounts5", csrCounts5, fC);
  endtask

  task automatic sample(input int c, input int lat);
    ping[c] = ~ping[c];
    step();
    repeat (lat - 1) step();
    echo[c] = ~echo[c];
    step();
  endtask

  initial begin
    mReset();
    repeat (3) @(posedge sysClk);
    #1;
    chk("rst_newValue", 32'(newValue), 32'd0);
    chk("rst_csrLatency", csrLatency, 32'd0);
    chk("rst_csrMinMax", csrMinMax, 32'd0);
    chk("rst_csrCounts", csrCounts, 32'd0);
    @(negedge sysClk);
    sysReset_n = 1'b1;
    rxValid = '1;
    step();

    // ch0 single sample of 37
    chanSel = 2'd0;
    sample(0, 37);
    chk("t1_strobe", 32'(newValue), 32'h1);
    step();
    chk("t1_strobe_gone", 32'(newValue), 32'h0);
    chk("t1_latency", csrLatency, {16'd37, 16'd37});
    chk("t1_counts", csrCounts, {16'd1, 8'd0, 8'd0});

    // ch1 timeout
    chanSel = 2'd1;
    ping[1] = ~ping[1];
    step();
    repeat (1000) step();
    step();
    chk("t2_counts", csrCounts, {16'd0, 8'd1, 8'd0});
    chk("t2_latest", csrLatency & 32'hFFFF, 32'd0);

    // ch2 two aborts then a completion
    chanSel = 2'd2;
    ping[2] = ~ping[2];
    step();
    repeat (5) step();
    rxValid[2] = 1'b0;
    step();
    rxValid[2] = 1'b1;
    ping[2] = ~ping[2];
    step();
    repeat (3) step();
    ping[2] = ~ping[2];
    step();
    repeat (2) step();
    echo[2] = ~echo[2];
    step();
    step();
    chk("t3_ch2_counts", csrCounts, {16'd1, 8'd0, 8'd2});
    chk("t3_ch2_latest", csrLatency & 32'hFFFF, 32'd3);

    // ch3 echo and ping together
    chanSel = 2'd3;
    ping[3] = ~ping[3];
    step();
    repeat (9) step();
    ping[3] = ~ping[3];
    echo[3] = ~echo[3];
    step();
    chk("t3_ch3_strobe", 32'(newValue), 32'h8);
    repeat (4) step();
    echo[3] = ~echo[3];
    step();
    step();
    chk("t3_ch3_latest", csrLatency & 32'hFFFF, 32'd5);
    chk("t3_ch3_counts", csrCounts, {16'd2, 8'd0, 8'd0});

    // abort counter saturation
    chanSel = 2'd2;
    repeat (300) begin
      ping[2] = ~ping[2];
      step();
    end
    step();
    chk("sat_abort", csrCounts & 32'hFF, 32'hFF);

    // filter after clear: 40 then 48
    chanSel = 2'd0;
    clearStats = 1'b1;
    step();
    clearStats = 1'b0;
    sample(0, 40);
    step();
    chk("t4_avg1", csrLatency, {16'd40, 16'd40});
    sample(0, 48);
    step();
    chk("t4_avg2", csrLatency, {16'd41, 16'd48});
    chk("t4_counts", csrCounts, {16'd2, 8'd0, 8'd0});

    // min/max
    clearStats = 1'b1;
    step();
    clearStats = 1'b0;
    sample(0, 37);
    sample(0, 100);
    sample(0, 20);
    step();
`ifdef LATENCY_METER_MINMAX_EN
    chk("t5_minmax", csrMinMax, {16'd100, 16'd20});
`else
    chk("t5_minmax", csrMinMax, 32'd0);
`endif
    clearStats = 1'b1;
    step();
    clearStats = 1'b0;
    step();
    chk("t5_clr_minmax", csrMinMax, 32'd0);
    chk("t5_clr_counts", csrCounts, 32'd0);

    // clear landing on a completion
    ping[0] = ~ping[0];
    step();
    repeat (14) step();
    echo[0] = ~echo[0];
    clearStats = 1'b1;
    step();
    clearStats = 1'b0;
    step();
    chk("t5_clr_done_counts", csrCounts, {16'd1, 8'd0, 8'd0});
    chk("t5_clr_done_lat", csrLatency, {16'd15, 16'd15});
`ifdef LATENCY_METER_MINMAX_EN
    chk("t5_clr_done_mm", csrMinMax, {16'd15, 16'd15});
`else
    chk("t5_clr_done_mm", csrMinMax, 32'd0);
`endif

    // out-of-range select on the 5-channel instance
    chanSel5 = 3'd5;
    step();
    chk("sel5_lat", csrLatency5, 32'd0);
    chk("sel5_cnt", csrCounts5, 32'd0);

    // reset in the middle of a measurement
    ping[0] = ~ping[0];
    step();
    repeat (10) step();
    sysReset_n = 1'b0;
    ping = '0;
    echo = '0;
    #2;
    chk("mrst_lat", csrLatency, 32'd0);
    chk("mrst_cnt", csrCounts, 32'd0);
    repeat (2) @(posedge sysClk);
    #1;
    chk("mrst_strobe", 32'(newValue), 32'd0);
    mReset();
    @(negedge sysClk);
    sysReset_n = 1'b1;
    step();
    echo[0] = ~echo[0];
    step();
    repeat (3) step();
    sample(0, 12);
    step();
    chk("mrst_after", csrLatency, {16'd12, 16'd12});

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < NCHAN; c++) begin
        rxValid[c] = ($urandom_range(0, 199) != 0);
        if ($urandom_range(0, 39) == 0) ping[c] = ~ping[c];
        if ($urandom_range(0, 14) == 0) echo[c] = ~echo[c];
      end
      clearStats = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) chanSel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) chanSel5 = 3'($urandom_range(0, 7));
      step();
    end
    clearStats = 1'b0;
    step();

    $display("%0d/%0d checks passed", totalCnt - failCnt, totalCnt);
    $finish;
  end

endmodule
